usb_buffer_arbiter: RTL and testbench

//  Sequences every access to the single-port USB data buffer RAM. Four requesters share it:
//  - USB RX store (rx_store), USB TX fetch (tx_get), AHB TX store (ahb_store), AHB RX fetch (ahb_get).

---
 rtl/usb_buf_pkg.sv | 24 ++
 rtl/usb_buf_ptr_ctrl.sv | 47 ++++
 rtl/usb_buffer_arbiter.sv | 178 +++++++++++++++++
 tb/tb_usb_buffer_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared types and sizing for the USB data-buffer arbiter and its pointer controller.
package usb_buf_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_RX_STORE  = 2'd0,
    REQ_TX_GET    = 2'd1,
    REQ_AHB_STORE = 2'd2,
    REQ_AHB_GET   = 2'd3
  } req_id_t;

  function automatic logic is_store(req_id_t id);
    return (id == REQ_RX_STORE) || (id == REQ_AHB_STORE);
  endfunction

endpackage

// File: rtl/usb_buf_ptr_ctrl.sv
// FIFO write/read pointers and occupancy for the buffer RAM; flush/clear win over any
// same-cycle update, and full/empty gate the pointer moves.
module usb_buf_ptr_ctrl
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clear,
  input  logic          store_en,
  input  logic          get_en,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   occupancy,
  output logic          full,
  output logic          empty
);

  logic wr_ok;
  logic rd_ok;

  assign full  = (occupancy == (AW+1)'(DEPTH));
  assign empty = (occupancy == '0);
  assign wr_ok = store_en && !full;
  assign rd_ok = get_en && !empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else if (flush || clear) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      occupancy <= occupancy + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Single-port buffer RAM arbiter: rx_store > tx_get > AHB (store/get round-robin).
// Optional AHB aging promotion is built when USB_BUF_ARB_AGING_EN is defined.
module usb_buffer_arbiter
  import usb_buf_pkg::*;
#(
  parameter int DEPTH     = BUF_DEPTH,
  parameter int AGE_LIMIT = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clear,
  input  logic          rx_store_req,
  input  logic [7:0]    rx_store_data,
  output logic          rx_store_ack,
  input  logic          tx_get_req,
  output logic          tx_get_ack,
  output logic [7:0]    tx_get_data,
  output logic          tx_get_valid,
  input  logic          ahb_store_req,
  input  logic [7:0]    ahb_store_data,
  output logic          ahb_store_ack,
  input  logic          ahb_get_req,
  output logic          ahb_get_ack,
  output logic [7:0]    ahb_get_data,
  output logic          ahb_get_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [AW:0]   buffer_occupancy,
  output logic          overflow_err,
  output logic          underflow_err
);

  arb_state_t   state, state_nxt;
  req_id_t      winner_q, pick, ahb_pick;
  logic         any_req;
  logic         rr_q;
  logic         empty_hit_q;
  logic         aged_store, aged_get;
  logic [7:0]   rd_byte, tx_data_q, ahb_data_q;
  logic [AW-1:0] wptr, rptr;
  logic         full, empty;
  logic         store_en, get_en;

  assign store_en = (state == GRANT) && is_store(winner_q);
  assign get_en   = (state == GRANT) && !is_store(winner_q);

  usb_buf_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .clear     (clear),
    .store_en  (store_en),
    .get_en    (get_en),
    .wptr      (wptr),
    .rptr      (rptr),
    .occupancy (buffer_occupancy),
    .full      (full),
    .empty     (empty)
  );

`ifdef USB_BUF_ARB_AGING_EN
  localparam int CW = $clog2(AGE_LIMIT + 1);
  logic [CW-1:0] age_store, age_get;

  // Counts only IDLE cycles, so a request ages once per arbitration round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_store <= '0;
      age_get   <= '0;
    end else if (state == IDLE) begin
      if (!ahb_store_req || pick == REQ_AHB_STORE) age_store <= '0;
      else if (age_store != CW'(AGE_LIMIT))        age_store <= age_store + CW'(1);
      if (!ahb_get_req || pick == REQ_AHB_GET)     age_get <= '0;
      else if (age_get != CW'(AGE_LIMIT))          age_get <= age_get + CW'(1);
    end
  end

  assign aged_store = ahb_store_req && (age_store == CW'(AGE_LIMIT));
  assign aged_get   = ahb_get_req && (age_get == CW'(AGE_LIMIT));
`else
  logic unused_age;
  assign unused_age = (AGE_LIMIT != 0);
  assign aged_store = 1'b0;
  assign aged_get   = 1'b0;
`endif

  always_comb begin
    any_req  = rx_store_req || tx_get_req || ahb_store_req || ahb_get_req;
    ahb_pick = (ahb_store_req && !(ahb_get_req && rr_q)) ? REQ_AHB_STORE : REQ_AHB_GET;
    if (aged_store || aged_get)
      pick = (aged_store && aged_get) ? ahb_pick : (aged_store ? REQ_AHB_STORE : REQ_AHB_GET);
    else if (rx_store_req) pick = REQ_RX_STORE;
    else if (tx_get_req)   pick = REQ_TX_GET;
    else                   pick = ahb_pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = is_store(winner_q) ? IDLE : RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q    <= REQ_RX_STORE;
      rr_q        <= 1'b0;
      empty_hit_q <= 1'b0;
      tx_data_q   <= '0;
      ahb_data_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        winner_q <= pick;
        if (pick == REQ_AHB_STORE || pick == REQ_AHB_GET) rr_q <= ~rr_q;
      end
      if (state == GRANT) empty_hit_q <= empty;
      if (state == RDATA && winner_q == REQ_TX_GET)  tx_data_q  <= rd_byte;
      if (state == RDATA && winner_q == REQ_AHB_GET) ahb_data_q <= rd_byte;
    end
  end

  // An empty read returns zero instead of stale RAM contents.
  assign rd_byte      = empty_hit_q ? 8'h00 : mem_rdata;
  assign tx_get_data  = (state == RDATA && winner_q == REQ_TX_GET)  ? rd_byte : tx_data_q;
  assign ahb_get_data = (state == RDATA && winner_q == REQ_AHB_GET) ? rd_byte : ahb_data_q;

  always_comb begin
    rx_store_ack  = 1'b0;
    tx_get_ack    = 1'b0;
    ahb_store_ack = 1'b0;
    ahb_get_ack   = 1'b0;
    tx_get_valid  = 1'b0;
    ahb_get_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    overflow_err  = 1'b0;
    underflow_err = 1'b0;
    case (state)
      GRANT: begin
        case (winner_q)
          REQ_RX_STORE:  rx_store_ack  = 1'b1;
          REQ_TX_GET:    tx_get_ack    = 1'b1;
          REQ_AHB_STORE: ahb_store_ack = 1'b1;
          REQ_AHB_GET:   ahb_get_ack   = 1'b1;
          default: ;
        endcase
        if (is_store(winner_q)) begin
          mem_addr     = wptr;
          mem_we       = !full;
          mem_wdata    = (winner_q == REQ_RX_STORE) ? rx_store_data : ahb_store_data;
          overflow_err = full;
        end else begin
          mem_addr      = rptr;
          underflow_err = empty;
        end
      end
      RDATA: begin
        tx_get_valid  = (winner_q == REQ_TX_GET);
        ahb_get_valid = (winner_q == REQ_AHB_GET);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Bench for usb_buffer_arbiter: queue-based FIFO reference, per-cycle compare, directed and random stimulus.
module tb_usb_buffer_arbiter;

  localparam int DEPTH     = 64;
  localparam int AW        = 6;
  localparam int AGE_LIMIT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    req = 4'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [7:0]    ahb_data = 8'h00;
  logic          rx_store_ack, tx_get_ack, ahb_store_ack, ahb_get_ack;
  logic          tx_get_valid, ahb_get_valid;
  logic [7:0]    tx_get_data, ahb_get_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic [AW:0]   buffer_occupancy;
  logic          overflow_err, underflow_err;
  logic [3:0]    ack_vec;

  int n_checks = 0;
  int n_pass   = 0;

  usb_buffer_arbiter #(.DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .clear            (clear),
    .rx_store_req     (req[0]),
    .rx_store_data    (rx_data),
    .rx_store_ack     (rx_store_ack),
    .tx_get_req       (req[1]),
    .tx_get_ack       (tx_get_ack),
    .tx_get_data      (tx_get_data),
    .tx_get_valid     (tx_get_valid),
    .ahb_store_req    (req[2]),
    .ahb_store_data   (ahb_data),
    .ahb_store_ack    (ahb_store_ack),
    .ahb_get_req      (req[3]),
    .ahb_get_ack      (ahb_get_ack),
    .ahb_get_data     (ahb_get_data),
    .ahb_get_valid    (ahb_get_valid),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .buffer_occupancy (buffer_occupancy),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
  );

  assign ack_vec = {ahb_get_ack, ahb_store_ack, tx_get_ack, rx_store_ack};

  // Clock / reset
  always #5 clk = ~clk;

  // Synchronous-read RAM behind the arbiter
  logic [7:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents as a byte queue plus the access in flight
  logic [7:0] exp_q[$];
  int   m_wa = 0, m_ra = 0;
  int   m_grant = -1, m_read = -1;
  logic [7:0] m_rdata = 8'h00;
  bit   m_rr = 1'b0;
  int   m_age [4] = '{0, 0, 0, 0};
  bit   model_on = 1'b0;

  function automatic bit is_wr(int id);
    return (id == 0) || (id == 2);
  endfunction

  always @(posedge clk) begin
    if (model_on) begin : model_step
      int  nxt_grant, nxt_read, w;
      bit  aged_s, aged_g;
      nxt_grant = -1;
      nxt_read  = -1;
      if (m_grant != -1) begin
        if (is_wr(m_grant)) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back(m_grant == 0 ? rx_data : ahb_data);
            m_wa = (m_wa + 1) % DEPTH;
          end
        end else begin
          nxt_read = m_grant;
          if (exp_q.size() == 0) m_rdata = 8'h00;
          else begin
            m_rdata = exp_q.pop_front();
            m_ra = (m_ra + 1) % DEPTH;
          end
        end
      end else if (m_read == -1 && req != 4'b0) begin
        aged_s = 1'b0;
        aged_g = 1'b0;
`ifdef USB_BUF_ARB_AGING_EN
        aged_s = req[2] && (m_age[2] >= AGE_LIMIT);
        aged_g = req[3] && (m_age[3] >= AGE_LIMIT);
`endif
        if (aged_s || aged_g)          w = (aged_s && aged_g) ? (m_rr ? 3 : 2) : (aged_s ? 2 : 3);
        else if (req[0])               w = 0;
        else if (req[1])               w = 1;
        else if (req[2] && req[3])     w = m_rr ? 3 : 2;
        else                           w = req[2] ? 2 : 3;
        if (w >= 2) m_rr = !m_rr;
        for (int i = 2; i < 4; i++) begin
          if (!req[i] || w == i) m_age[i] = 0;
          else if (m_age[i] < AGE_LIMIT) m_age[i]++;
        end
        nxt_grant = w;
      end else if (m_read == -1) begin
        m_age[2] = 0;
        m_age[3] = 0;
      end
      if (flush || clear) begin
        exp_q.delete();
        m_wa = 0;
        m_ra = 0;
      end
      m_grant = nxt_grant;
      m_read  = nxt_read;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (model_on) begin : compare
      logic [3:0] e_ack;
      logic [1:0] e_valid, e_err;
      logic       e_we, full_now, empty_now;
      full_now  = (exp_q.size() == DEPTH);
      empty_now = (exp_q.size() == 0);
      e_ack = 4'b0; e_valid = 2'b0; e_err = 2'b0; e_we = 1'b0;
      if (m_grant != -1) begin
        e_ack[m_grant] = 1'b1;
        if (is_wr(m_grant)) begin
          e_we = !full_now;
          e_err[1] = full_now;
          check("store_addr", 32'(mem_addr), 32'(m_wa));
          if (e_we) check("store_wdata", 32'(mem_wdata), 32'(m_grant == 0 ? rx_data : ahb_data));
        end else begin
          e_err[0] = empty_now;
          check("get_addr", 32'(mem_addr), 32'(m_ra));
        end
      end
      if (m_read == 1) begin
        e_valid[0] = 1'b1;
        check("tx_get_data", 32'(tx_get_data), 32'(m_rdata));
      end
      if (m_read == 3) begin
        e_valid[1] = 1'b1;
        check("ahb_get_data", 32'(ahb_get_data), 32'(m_rdata));
      end
      check("acks", 32'(ack_vec), 32'(e_ack));
      check("valids", 32'({ahb_get_valid, tx_get_valid}), 32'(e_valid));
      check("mem_we", 32'(mem_we), 32'(e_we));
      check("errs", 32'({overflow_err, underflow_err}), 32'(e_err));
      check("occupancy", 32'(buffer_occupancy), 32'(exp_q.size()));
    end
  end

  // Driver tasks
  task automatic set_data(input int id, input logic [7:0] d);
    if (id == 0) rx_data = d;
    else if (id == 2) ahb_data = d;
  endtask

  task automatic do_req(input int id, input logic [7:0] d, output int lat,
                        output logic [AW-1:0] addr, output logic we,
                        output logic err, output logic [7:0] rdata);
    bit got;
    got = 1'b0; lat = 0; addr = '0; we = 1'b0; err = 1'b0; rdata = 8'h00;
    req[id] = 1'b1;
    set_data(id, d);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ack_vec[id]) begin
        got  = 1'b1;
        addr = mem_addr;
        we   = mem_we;
        err  = overflow_err | underflow_err;
      end
    end
    if (!got) check("req_timeout", 32'(lat), 32'(0));
    else if (!is_wr(id)) begin
      @(negedge clk);
      rdata = (id == 1) ? tx_get_data : ahb_get_data;
    end
    @(posedge clk); #1;
    req[id] = 1'b0;
  endtask

  // Asserts the masked requests and records the order of acks; hold re-requests after each ack.
  task automatic run_group(input logic [3:0] mask, input bit hold, input int ngrants,
                           output int seq [48], output int n);
    logic [3:0] acked;
    int cyc;
    n = 0; cyc = 0;
    for (int i = 0; i < 48; i++) seq[i] = -1;
    req = mask;
    rx_data = 8'h3C; ahb_data = 8'hC3;
    while (n < ngrants && cyc < 400) begin
      @(negedge clk);
      cyc++;
      acked = ack_vec;
      for (int i = 0; i < 4; i++) if (acked[i] && n < 48) begin seq[n] = i; n++; end
      @(posedge clk); #1;
      if (!hold) req = req & ~acked;
    end
    if (n < ngrants) check("group_timeout", 32'(n), 32'(ngrants));
    req = 4'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic random_phase(input int ncyc, input int p_st, input int p_get);
    logic [3:0] seen;
    int c;
    bit winding;
    c = 0;
    while (c < ncyc + 100) begin
      @(negedge clk);
      seen = ack_vec;
      @(posedge clk); #1;
      c++;
      winding = (c >= ncyc);
      if (winding && req == 4'b0) break;
      flush = !winding && ($urandom_range(0, 80) == 0);
      clear = !winding && ($urandom_range(0, 120) == 0);
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (seen[i]) begin
            if (!winding && $urandom_range(0, 3) == 0) set_data(i, 8'($urandom));
            else req[i] = 1'b0;
          end
        end else if (!winding && $urandom_range(0, 99) < (is_wr(i) ? p_st : p_get)) begin
          req[i] = 1'b1;
          set_data(i, 8'($urandom));
        end
      end
    end
    flush = 1'b0;
    clear = 1'b0;
    check("random_drain", 32'(req), 32'(0));
    req = 4'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin : main
    int lat, n, first3, bad;
    int seq [48];
    logic [AW-1:0] addr;
    logic we, err;
    logic [7:0] rd;

    repeat (3) @(posedge clk);
    #1;
    check("reset_occupancy", 32'(buffer_occupancy), 32'(0));
    check("reset_acks", 32'(ack_vec), 32'(0));
    check("reset_mem_we", 32'(mem_we), 32'(0));
    rst = 1'b0;
    model_on = 1'b1;
    @(posedge clk); #1;

    // Single store: ack one cycle after the request is seen
    do_req(0, 8'hA5, lat, addr, we, err, rd);
    check("t1_latency", 32'(lat), 32'(2));
    check("t1_addr", 32'(addr), 32'(0));
    check("t1_we", 32'(we), 32'(1));
    check("t1_occupancy", 32'(buffer_occupancy), 32'(1));

    // FIFO order on read
    do_req(0, 8'h11, lat, addr, we, err, rd);
    do_req(0, 8'h22, lat, addr, we, err, rd);
    check("t2_occ3", 32'(buffer_occupancy), 32'(3));
    do_req(1, 8'h00, lat, addr, we, err, rd);
    check("t2_data0", 32'(rd), 32'hA5);
    check("t2_occ2", 32'(buffer_occupancy), 32'(2));
    do_req(1, 8'h00, lat, addr, we, err, rd);
    check("t2_rptr1", 32'(addr), 32'(1));
    check("t2_data1", 32'(rd), 32'h11);

    // Priority and AHB round-robin
    run_group(4'b1001, 1'b0, 2, seq, n);
    check("t3_rx_first", 32'(seq[0]), 32'(0));
    check("t3_ahb_second", 32'(seq[1]), 32'(3));
    run_group(4'b1100, 1'b1, 6, seq, n);
    bad = 0;
    for (int k = 1; k < 6; k++) if (seq[k] == seq[k-1] || seq[k] < 2) bad++;
    check("t3_alternate", 32'(bad), 32'(0));

    // Fill, overflow, drain, underflow
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t4_flush", 32'(buffer_occupancy), 32'(0));
    for (int i = 0; i < DEPTH; i++) do_req(2, 8'(i), lat, addr, we, err, rd);
    check("t4_full", 32'(buffer_occupancy), 32'(DEPTH));
    do_req(2, 8'hEE, lat, addr, we, err, rd);
    check("t4_overflow_err", 32'(err), 32'(1));
    check("t4_overflow_we", 32'(we), 32'(0));
    check("t4_still_full", 32'(buffer_occupancy), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_req(3, 8'h00, lat, addr, we, err, rd);
      if (rd !== 8'(i)) bad++;
    end
    check("t4_drain_data", 32'(bad), 32'(0));
    do_req(3, 8'h00, lat, addr, we, err, rd);
    check("t4_underflow_err", 32'(err), 32'(1));
    check("t4_underflow_data", 32'(rd), 32'h00);
    check("t4_empty", 32'(buffer_occupancy), 32'(0));

    // Pointer wrap at DEPTH-1
    for (int i = 0; i < DEPTH - 1; i++) begin
      do_req(0, 8'(i + 7), lat, addr, we, err, rd);
      do_req(1, 8'h00, lat, addr, we, err, rd);
    end
    do_req(0, 8'h5A, lat, addr, we, err, rd);
    check("t5_addr63", 32'(addr), 32'(DEPTH - 1));
    do_req(0, 8'h6B, lat, addr, we, err, rd);
    check("t5_addr_wrap", 32'(addr), 32'(0));

    // clear during GRANT: ack still issued, occupancy reset
    req[2] = 1'b1;
    ahb_data = 8'h77;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    check("t5_clear_ack", 32'(ahb_store_ack), 32'(1));
    @(posedge clk); #1;
    clear = 1'b0;
    req[2] = 1'b0;
    check("t5_clear_occ", 32'(buffer_occupancy), 32'(0));

    // Randomized traffic, balanced then store-heavy
    random_phase(1500, 25, 25);
    random_phase(1500, 45, 10);

    // USB traffic held against a pending AHB get
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    run_group(4'b1001, 1'b1, 40, seq, n);
    first3 = -1;
    for (int k = 0; k < 40; k++) if (seq[k] == 3 && first3 < 0) first3 = k;
`ifdef USB_BUF_ARB_AGING_EN
    check("t6_aged_grant", 32'(first3 >= 0 && first3 <= AGE_LIMIT + 2), 32'(1));
`else
    check("t6_starved", 32'(first3), 32'(-1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
